// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Runs RV32I loads and stores from the MEM stage onto an AHB-Lite data bus. It takes
//   one request per handshake and checks alignment before starting a bus access. After
//   the address and data phases it aligns and extends load data, then returns exactly
//   one response pulse.
// Ports
//   clk_in, rst_in         clock (rising edge); asynchronous active-high reset
//   req_*                  MEM-stage request handshake and fields
//   rsp_*                  one-cycle response: load data, bus error, misalignment
//   busy_out               high whenever the controller is not idle (MEM-stage stall)
//   h*                     AHB-Lite master signals
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        req_valid_in,
   output logic        req_ready_out,
   input  logic        req_write_in,
   input  logic [1:0]  req_size_in,
   input  logic        req_unsigned_in,
   input  logic [31:0] req_addr_in,
   input  logic [31:0] req_wdata_in,
   output logic        rsp_valid_out,
   output logic [31:0] rsp_rdata_out,
   output logic        rsp_err_out,
   output logic        rsp_misalign_out,
   output logic        busy_out,
   output logic [31:0] haddr_out,
   output logic [1:0]  htrans_out,
   output logic        hwrite_out,
   output logic [2:0]  hsize_out,
   output logic [31:0] hwdata_out,
   input  logic [31:0] hrdata_in,
   input  logic        hready_in,
   input  logic        hresp_in
);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_t;

   localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
   localparam bit               TimeoutEn  = (TIMEOUT_CYCLES != 0);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              uns_q, uns_d;
   logic [31:0]       haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [1:0]        hsize_q, hsize_d;
   logic [31:0]       hwdata_q, hwdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              mis_q, mis_d;
   logic              misaligned;

   // Picks the addressed lane out of the bus word and sign- or zero-extends it.
   function automatic logic [31:0] load_align(input logic [31:0] d, input logic [1:0] a,
                                              input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(d >> {a, 3'b000});
      h = a[1] ? d[31:16] : d[15:0];
      case (sz)
         2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return d;
      endcase
   endfunction

   assign misaligned = (req_size_in == 2'b11) ||
                       ((req_size_in == 2'b01) && req_addr_in[0]) ||
                       ((req_size_in == 2'b10) && (req_addr_in[1:0] != 2'b00));

   // Saturate so a disabled timeout can never wrap into a false match.
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   assign req_ready_out    = (state_q == StIdle) && !rst_in;
   assign busy_out         = (state_q != StIdle);
   assign rsp_valid_out    = (state_q == StResp);
   assign rsp_rdata_out    = rdata_q;
   assign rsp_err_out      = err_q;
   assign rsp_misalign_out = mis_q;
   assign htrans_out       = (state_q == StAddr) ? 2'b10 : 2'b00;
   assign haddr_out        = haddr_q;
   assign hwrite_out       = hwrite_q;
   assign hsize_out        = {1'b0, hsize_q};
   assign hwdata_out       = hwdata_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      uns_d    = uns_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      hwdata_d = hwdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      mis_d    = mis_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_in && req_ready_out) begin
               if (misaligned) begin
                  // Bus registers are left alone: no access happens for this request.
                  state_d = StResp;
                  mis_d   = 1'b1;
                  err_d   = 1'b0;
                  rdata_d = 32'h0;
               end else begin
                  state_d  = StAddr;
                  uns_d    = req_unsigned_in;
                  haddr_d  = req_addr_in;
                  hwrite_d = req_write_in;
                  hsize_d  = req_size_in;
                  case (req_size_in)
                     2'b00:   hwdata_d = {4{req_wdata_in[7:0]}};
                     2'b01:   hwdata_d = {2{req_wdata_in[15:0]}};
                     default: hwdata_d = req_wdata_in;
                  endcase
               end
            end
         end
         StAddr: begin
            if (hready_in) begin
               state_d = StData;
               cnt_d   = '0;
            end
         end
         StData: begin
            if (hresp_in) begin
               state_d = StResp;
               err_d   = 1'b1;
               mis_d   = 1'b0;
               rdata_d = 32'h0;
            end else if (hready_in) begin
               state_d = StResp;
               err_d   = 1'b0;
               mis_d   = 1'b0;
               rdata_d = hwrite_q ? 32'h0 : load_align(hrdata_in, haddr_q[1:0], hsize_q, uns_q);
            end else begin
               cnt_d = cnt_inc;
               if (TimeoutEn && (cnt_inc == TimeoutVal)) begin
                  state_d = StResp;
                  err_d   = 1'b1;
                  mis_d   = 1'b0;
                  rdata_d = 32'h0;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         uns_q    <= 1'b0;
         haddr_q  <= 32'h0;
         hwrite_q <= 1'b0;
         hsize_q  <= 2'b00;
         hwdata_q <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         uns_q    <= uns_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         hwdata_q <= hwdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         mis_q    <= mis_d;
      end
   end

endmodule
